// File: rtl/iir_pkg.sv
// Shared register map, coefficient defaults and FSM encoding for the biquad core.
package iir_pkg;

  localparam logic [3:0] ADDR_B0      = 4'd0;
  localparam logic [3:0] ADDR_B1      = 4'd1;
  localparam logic [3:0] ADDR_B2      = 4'd2;
  localparam logic [3:0] ADDR_A1      = 4'd3;
  localparam logic [3:0] ADDR_A2      = 4'd4;
  localparam logic [3:0] ADDR_CTRL    = 4'd5;
  localparam logic [3:0] ADDR_SAMPLES = 4'd6;
  localparam logic [3:0] ADDR_SATS    = 4'd7;
  localparam logic [3:0] ADDR_DROPS   = 4'd8;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_BYPASS_BIT = 1;

  localparam int N_COEF = 5;
  localparam int DEF_B0 = 8275;
  localparam int DEF_B1 = -16383;
  localparam int DEF_B2 = 8275;
  localparam int DEF_A1 = -31035;
  localparam int DEF_A2 = 14969;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_ROUND, S_OUT
  } state_t;

  function automatic int default_coef(int idx);
    case (idx)
      0:       return DEF_B0;
      1:       return DEF_B1;
      2:       return DEF_B2;
      3:       return DEF_A1;
      default: return DEF_A2;
    endcase
  endfunction

  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iir_biquad_if.sv
// Stream-in, stream-out and register-slave signals of the biquad core.
interface iir_biquad_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic [CH_W-1:0]          in_ch;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_sat;
  logic                     slave_write;
  logic                     slave_read;
  logic [3:0]               slave_address;
  logic [31:0]              slave_writedata;
  logic [31:0]              slave_readdata;

  modport master (
    output in_valid, in_data, in_ch, out_ready,
           slave_write, slave_read, slave_address, slave_writedata,
    input  in_ready, out_valid, out_data, out_ch, out_sat, slave_readdata
  );

  modport slave (
    input  in_valid, in_data, in_ch, out_ready,
           slave_write, slave_read, slave_address, slave_writedata,
    output in_ready, out_valid, out_data, out_ch, out_sat, slave_readdata
  );
endinterface

// File: rtl/iir_round_sat.sv
// Round-half-up, arithmetic shift by FRAC_BITS and clamp to signed DATA_W.
module iir_round_sat #(
  parameter int ACC_W     = 51,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 14
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_sat
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] Y_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Y_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shift;

  assign w_sum   = {i_acc[ACC_W-1], i_acc} + HALF;
  assign w_shift = w_sum >>> FRAC_BITS;

  always_comb begin
    o_y   = w_shift[DATA_W-1:0];
    o_sat = 1'b0;
    if (w_shift > Y_MAX) begin
      o_y   = Y_MAX[DATA_W-1:0];
      o_sat = 1'b1;
    end else if (w_shift < Y_MIN) begin
      o_y   = Y_MIN[DATA_W-1:0];
      o_sat = 1'b1;
    end
  end
endmodule

// File: rtl/iir_biquad_core.sv
// Time-multiplexed direct-form-I biquad: one shared multiplier, per-channel history,
// result 7 cycles after accept and held until out_ready; input stalls while busy.
module iir_biquad_core
  import iir_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 14,
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = DATA_W + COEF_W + 3
) (
  input  logic         clk,
  input  logic         reset,
  iir_biquad_if.slave  bus,
  output logic         o_busy
);
  localparam int CH_W   = ch_width(NUM_CH);
  localparam int PROD_W = DATA_W + COEF_W;

  state_t                   r_state, w_next;
  logic signed [COEF_W-1:0] r_coef [N_COEF];
  logic signed [COEF_W-1:0] r_snap [N_COEF];
  logic                     r_bypass, r_snap_bypass, r_clear_pending;
  logic signed [DATA_W-1:0] r_x1 [NUM_CH];
  logic signed [DATA_W-1:0] r_x2 [NUM_CH];
  logic signed [DATA_W-1:0] r_y1 [NUM_CH];
  logic signed [DATA_W-1:0] r_y2 [NUM_CH];
  logic signed [DATA_W-1:0] r_x;
  logic [CH_W-1:0]          r_ch;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]          r_out_ch;
  logic                     r_out_sat;
  logic [31:0]              r_sample_cnt, r_sat_cnt, r_drop_cnt, r_readdata;

  logic                     w_accept, w_drop, w_clear_now;
  logic signed [DATA_W-1:0] w_op_x;
  logic signed [COEF_W-1:0] w_op_c;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [DATA_W-1:0] w_y;
  logic                     w_sat;
  logic [31:0]              w_rdata;
  logic                     w_unused;

  assign bus.in_ready   = !reset && (r_state == S_IDLE) && !r_clear_pending;
  assign bus.out_valid  = (r_state == S_OUT);
  assign bus.out_data   = r_out_data;
  assign bus.out_ch     = r_out_ch;
  assign bus.out_sat    = r_out_sat;
  assign bus.slave_readdata = r_readdata;
  assign o_busy         = (r_state != S_IDLE);

  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_drop      = w_accept && (int'(bus.in_ch) >= NUM_CH);
  assign w_clear_now = (r_state == S_IDLE) && r_clear_pending;
  assign w_prod      = PROD_W'(w_op_x) * PROD_W'(w_op_c);
  assign w_prod_ext  = ACC_W'(w_prod);
  assign w_unused    = ^bus.slave_writedata[31:COEF_W];

  always_comb begin
    w_next = r_state;
    w_op_x = r_x;
    w_op_c = r_snap[0];
    unique case (r_state)
      S_IDLE:  if (w_accept && !w_drop) w_next = S_MAC0;
      S_MAC0:  w_next = S_MAC1;
      S_MAC1:  begin w_next = S_MAC2; w_op_x = r_x1[r_ch]; w_op_c = r_snap[1]; end
      S_MAC2:  begin w_next = S_MAC3; w_op_x = r_x2[r_ch]; w_op_c = r_snap[2]; end
      S_MAC3:  begin w_next = S_MAC4; w_op_x = r_y1[r_ch]; w_op_c = r_snap[3]; end
      S_MAC4:  begin w_next = S_ROUND; w_op_x = r_y2[r_ch]; w_op_c = r_snap[4]; end
      S_ROUND: w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (bus.slave_address)
      ADDR_B0, ADDR_B1, ADDR_B2, ADDR_A1, ADDR_A2:
                    w_rdata = 32'(r_coef[bus.slave_address[2:0]]);
      ADDR_CTRL:    w_rdata = {30'd0, r_bypass, r_clear_pending};
      ADDR_SAMPLES: w_rdata = r_sample_cnt;
      ADDR_SATS:    w_rdata = r_sat_cnt;
      ADDR_DROPS:   w_rdata = r_drop_cnt;
      default:      w_rdata = '0;
    endcase
  end

  iir_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_round (
    .i_acc (r_acc),
    .o_y   (w_y),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_bypass        <= 1'b0;
      r_snap_bypass   <= 1'b0;
      r_clear_pending <= 1'b0;
      r_x             <= '0;
      r_ch            <= '0;
      r_acc           <= '0;
      r_out_data      <= '0;
      r_out_ch        <= '0;
      r_out_sat       <= 1'b0;
      r_sample_cnt    <= '0;
      r_sat_cnt       <= '0;
      r_drop_cnt      <= '0;
      r_readdata      <= '0;
      for (int i = 0; i < N_COEF; i++) begin
        r_coef[i] <= COEF_W'(default_coef(i));
        r_snap[i] <= COEF_W'(default_coef(i));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        r_x1[c] <= '0; r_x2[c] <= '0; r_y1[c] <= '0; r_y2[c] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_clear_now) begin
        r_clear_pending <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_x1[c] <= '0; r_x2[c] <= '0; r_y1[c] <= '0; r_y2[c] <= '0;
        end
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end else if (w_accept) begin
        // The snapshot isolates the in-flight sample from later register writes.
        r_x           <= bus.in_data;
        r_ch          <= bus.in_ch;
        r_snap        <= r_coef;
        r_snap_bypass <= r_bypass;
      end
      case (r_state)
        S_MAC0:         r_acc <= w_prod_ext;
        S_MAC1, S_MAC2: r_acc <= r_acc + w_prod_ext;
        S_MAC3, S_MAC4: r_acc <= r_acc - w_prod_ext;
        S_ROUND: begin
          r_out_ch     <= r_ch;
          r_sample_cnt <= r_sample_cnt + 32'd1;
          if (r_snap_bypass) begin
            r_out_data <= r_x;
            r_out_sat  <= 1'b0;
          end else begin
            r_out_data <= w_y;
            r_out_sat  <= w_sat;
            if (w_sat) r_sat_cnt <= r_sat_cnt + 32'd1;
            r_x2[r_ch] <= r_x1[r_ch];
            r_x1[r_ch] <= r_x;
            r_y2[r_ch] <= r_y1[r_ch];
            r_y1[r_ch] <= w_y;
          end
        end
        default: ;
      endcase
      // A new clear request placed after the apply so it is never lost.
      if (bus.slave_write) begin
        if (bus.slave_address <= ADDR_A2) begin
          r_coef[bus.slave_address[2:0]] <= bus.slave_writedata[COEF_W-1:0];
        end else if (bus.slave_address == ADDR_CTRL) begin
          r_bypass <= bus.slave_writedata[CTRL_BYPASS_BIT];
          if (bus.slave_writedata[CTRL_CLEAR_BIT]) r_clear_pending <= 1'b1;
        end
      end
      if (bus.slave_read) r_readdata <= w_rdata;
    end
  end
endmodule
